inverter_loop_tester: RTL and testbench
=======================================

# inverter_loop_tester

Digital stimulus and response-capture block for the analog double-inverter macro.
- Drives a test edge onto a pad that is looped externally into the inverter input.
- Samples the inverter output, which returns on a dedicated input pin.
- Measures the rise and fall loop delay in clock cycles.
- Flags polarity faults and timeouts.

It sits in the digital tile as the driving/reading end of the analog path. Results are readable on the bidirectional pins.

## Interface
- CNT_W, 8: delay counter and result width. Counters saturate at 2^CNT_W−1.
- SETTLE_CYCLES, 16: cycles the stimulus is held static before each measured edge.
- clk  input  1  clock
- rst_n  input  1  synchronous, active-low reset
- ena  input  1  always 1 when powered; ignored
- ui_in  input  8  [0] returned inverter output (asynchronous); [1] start (rising edge triggers a run); [2] invert-expect (1 = path expected inverting); [4] result select (0 = rise, 1 = fall); others unused
- uo_out  output  8  [0] stimulus; [1] busy; [2] done; [3] timeout; [4] polarity error; [7:5] FSM state code; all 0 in reset
- uio_in  input  8  unused
- uio_out  output  8  selected result, CNT_W bits; 0 in reset
- uio_oe  output  8  constant 8'hFF

## Operation
- ui_in[0] passes through a 2-flop synchronizer. ui_in[1] is registered and edge-detected.
- exp(x) = x XOR ui_in[2]. ui_in[2] is sampled at the start edge and held for the run.
- States and codes:
  - IDLE 0
  - SETTLE_LO 1
  - RISE 2
  - SETTLE_HI 3
  - FALL 4
  - DONE 5
  - ERROR 6
- IDLE, stim=0:
  - A start edge clears the done, timeout and perr flags and goes to SETTLE_LO.
  - Start edges in any other state are ignored.
  - A level held high on start gives exactly one run.
- SETTLE_LO, stim=0:
  - Lasts SETTLE_CYCLES cycles.
  - On the last cycle, if sync≠exp(0), set perr and go to ERROR. Otherwise go to RISE.
- RISE, stim=1:
  - The counter starts at 0 and increments each cycle while sync≠exp(1).
  - On the first match, latch the counter into rise_dly and go to SETTLE_HI.
  - If the counter reaches 2^CNT_W−1 without a match, set timeout, latch the saturated value and go to ERROR.
- SETTLE_HI, stim=1: same as SETTLE_LO with exp(1), then go to FALL.
- FALL, stim=0: mirrors RISE with exp(0) and writes fall_dly. A match goes to DONE.
- DONE and ERROR:
  - stim=0, busy=0.
  - Flags hold.
  - A start edge begins a new run.
- busy=1 in states SETTLE_LO through FALL.
- uio_out = ui_in[4] ? fall_dly : rise_dly. Selection is combinational from registered results.

## Timing
- Start edge sampled at edge E → SETTLE_LO from E+2 (one cycle register, one cycle edge detect).
- Reported delay includes the 2-cycle synchronizer:
  - With a zero-delay external loop, rise_dly = fall_dly = 2.
  - Each extra cycle of external delay adds 1.
- Results are stable one cycle after the FSM leaves RISE/FALL.
- done asserts in the same cycle the state becomes DONE.
- A reset asserted mid-run takes effect on the next clock:
  - state IDLE
  - stim 0
  - all flags 0
  - results 0
  - synchronizer flops 0
- A match and saturation in the same cycle counts as a match; timeout is not set.
- Results from the previous run persist until overwritten by the new run's RISE/FALL.

## Configuration
- LOOP_TESTER_AVG_EN defined:
  - Each run performs 4 rise/fall iterations.
  - After FALL, control returns to SETTLE_LO until 4 iterations are done.
  - Per-edge delays accumulate in CNT_W+2-bit sums. Reported results = sum>>2.
  - A perr or timeout in any iteration aborts to ERROR. Results then hold the last completed average, or 0.
- Undefined: single iteration; results are the raw counts.

## Structure
- Package inverter_loop_tester_pkg:
  - state enum with the fixed codes above
  - default CNT_W and SETTLE_CYCLES
  - iteration count constant (4)
- Sub-module loop_sync:
  - 2-flop synchronizer for ui_in[0]
  - register plus rising-edge detector for ui_in[1]
  - instantiated once

## Test plan
- Zero-delay loop (ui_in[0] = uo_out[0]), invert-expect 0, start pulse:
  - done=1
  - rise_dly=2, fall_dly=2
  - busy low after DONE
  - stim sequence 0 → 1 → 0
- Loop with a 5-cycle bench delay → uio_out=7 with select 0 and with select 1.
- ui_in[0] tied 0 (broken loop) → ERROR (state code 6), timeout=1, rise_dly=255, stim=0.
- Inverting loop with invert-expect 0 → perr=1 at the end of SETTLE_LO, timeout=0. Repeat with invert-expect 1 → done, delays 2.
- Reset asserted during RISE → next cycle all outputs 0 and state IDLE. A following start produces a clean run.
- Start held high through DONE → exactly one run. With LOOP_TESTER_AVG_EN and delays 3,3,4,4 → result 3.

Source files
------------

// File: rtl/inverter_loop_tester_pkg.sv
// Shared types and defaults for the inverter loop tester: FSM state codes,
// default widths and the iteration count used when averaging is enabled.
package inverter_loop_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTLE_LO = 3'd1,
      ST_RISE      = 3'd2,
      ST_SETTLE_HI = 3'd3,
      ST_FALL      = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERROR     = 3'd6
   } state_t;

   localparam int DEF_CNT_W         = 8;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int AVG_ITERS         = 4;

   function automatic logic is_busy(input state_t s);
      return s inside {ST_SETTLE_LO, ST_RISE, ST_SETTLE_HI, ST_FALL};
   endfunction

endpackage

// File: rtl/inverter_loop_tester_sync.sv
// Input conditioning: 2-flop synchronizer for the returned inverter output
// and a registered rising-edge detector for the start request.
module loop_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic ret_async,
   input  logic start,
   output logic ret_sync,
   output logic start_edge
);

   logic ret_meta;
   logic start_q;
   logic start_d;

   // NOTE: every flop here uses <= so all stages update from pre-edge values;
   // blocking assignments would collapse the chain into a single stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ret_meta   <= 1'b0;
         ret_sync   <= 1'b0;
         start_q    <= 1'b0;
         start_d    <= 1'b0;
         start_edge <= 1'b0;
      end else begin
         ret_meta   <= ret_async;
         ret_sync   <= ret_meta;
         start_q    <= start;
         start_d    <= start_q;
         start_edge <= start_q & ~start_d;
      end
   end

endmodule

// File: rtl/inverter_loop_tester.sv
// Stimulus/capture FSM for the analog double-inverter loop: measures rise and
// fall loop delay in cycles. Define LOOP_TESTER_AVG_EN to average 4 iterations.
module inverter_loop_tester
   import inverter_loop_tester_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic             stim, done, timeout, perr, inv;
   logic [CNT_W-1:0] cnt, rise_dly, fall_dly;
   logic [SET_W-1:0] settle_cnt;
   logic             ret_sync, start_edge;

`ifdef LOOP_TESTER_AVG_EN
   localparam int SUM_W = CNT_W + 2;
   localparam int IT_W  = $clog2(AVG_ITERS);
   logic [SUM_W-1:0] rise_sum, fall_sum;
   logic [IT_W-1:0]  iter;
`endif

   logic unused;
   assign unused = &{1'b0, ena, uio_in, ui_in[7:5], ui_in[3]};

   loop_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .ret_async  (ui_in[0]),
      .start      (ui_in[1]),
      .ret_sync   (ret_sync),
      .start_edge (start_edge)
   );

   // Expected levels are x ^ inv: inv for a low stimulus, ~inv for a high one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         stim       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         perr       <= 1'b0;
         inv        <= 1'b0;
         cnt        <= '0;
         settle_cnt <= '0;
         rise_dly   <= '0;
         fall_dly   <= '0;
`ifdef LOOP_TESTER_AVG_EN
         rise_sum   <= '0;
         fall_sum   <= '0;
         iter       <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_edge) begin
                  done       <= 1'b0;
                  timeout    <= 1'b0;
                  perr       <= 1'b0;
                  inv        <= ui_in[2];
                  settle_cnt <= '0;
                  state      <= ST_SETTLE_LO;
`ifdef LOOP_TESTER_AVG_EN
                  rise_sum   <= '0;
                  fall_sum   <= '0;
                  iter       <= '0;
`endif
               end
            end
            ST_SETTLE_LO: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  if (ret_sync != inv) begin
                     perr  <= 1'b1;
                     state <= ST_ERROR;
                  end else begin
                     stim  <= 1'b1;
                     cnt   <= '0;
                     state <= ST_RISE;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_RISE: begin
               if (ret_sync == ~inv) begin
`ifdef LOOP_TESTER_AVG_EN
                  rise_sum <= rise_sum + SUM_W'(cnt);
`else
                  rise_dly <= cnt;
`endif
                  state <= ST_SETTLE_HI;
               end else if (cnt == CNT_MAX) begin
`ifndef LOOP_TESTER_AVG_EN
                  rise_dly <= cnt;
`endif
                  timeout <= 1'b1;
                  stim    <= 1'b0;
                  state   <= ST_ERROR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SETTLE_HI: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  stim       <= 1'b0;
                  if (ret_sync != ~inv) begin
                     perr  <= 1'b1;
                     state <= ST_ERROR;
                  end else begin
                     cnt   <= '0;
                     state <= ST_FALL;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_FALL: begin
               if (ret_sync == inv) begin
`ifdef LOOP_TESTER_AVG_EN
                  if (iter == IT_W'(AVG_ITERS - 1)) begin
                     rise_dly <= CNT_W'(rise_sum >> IT_W);
                     fall_dly <= CNT_W'((fall_sum + SUM_W'(cnt)) >> IT_W);
                     done     <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     fall_sum <= fall_sum + SUM_W'(cnt);
                     iter     <= iter + 1'b1;
                     state    <= ST_SETTLE_LO;
                  end
`else
                  fall_dly <= cnt;
                  done     <= 1'b1;
                  state    <= ST_DONE;
`endif
               end else if (cnt == CNT_MAX) begin
`ifndef LOOP_TESTER_AVG_EN
                  fall_dly <= cnt;
`endif
                  timeout <= 1'b1;
                  state   <= ST_ERROR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign uo_out  = {state, perr, timeout, done, is_busy(state), stim};
   assign uio_out = 8'(ui_in[4] ? fall_dly : rise_dly);
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_inverter_loop_tester.sv
// Randomized self-checking bench for inverter_loop_tester: an external loop
// with programmable per-edge delay, compared against an arithmetic model.
module tb_inverter_loop_tester;

   localparam int SETTLE = 16;
   localparam int CMAX   = 255;
`ifdef LOOP_TESTER_AVG_EN
   localparam int ITERS = 4;
`else
   localparam int ITERS = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, inv_exp = 1'b0, sel = 1'b0;
   logic loop_inv = 1'b0, loop_broken = 1'b0;
   logic ret;
   logic [7:0] ui_in, uo_out, uio_out, uio_oe;
   logic [511:0] hist = '0;
   logic prev_stim = 1'b0;
   logic [8:0] dly = '0;
   int dq[$];
   int total = 0, bad = 0;
   int rdly[ITERS], fdly[ITERS];
   int exp_rise = 0, exp_fall = 0;
   int st, slo, rises, falls, runs, lat1, lat2;

   always #5 clk = ~clk;

   assign ui_in = {3'b000, sel, 1'b0, inv_exp, start, ret};
   always_comb ret = loop_broken ? 1'b0 : (((dly == 9'd0) ? uo_out[0] : hist[dly]) ^ loop_inv);

   // External loop: each stimulus edge takes the next delay from the queue.
   always @(negedge clk) begin
      if (uo_out[0] != prev_stim && dq.size() > 0) dly = 9'(dq.pop_front());
      prev_stim = uo_out[0];
      hist = {hist[510:0], uo_out[0]};
   end

   inverter_loop_tester dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (1'b1),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (8'h00),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Reported value = floor(mean over iterations of (external delay + 2)).
   function automatic int avg_of(input int d[ITERS]);
      int s = 0;
      for (int i = 0; i < ITERS; i++) s += d[i] + 2;
      return s / ITERS;
   endfunction

   task automatic read_res(output int r, output int f);
      sel = 1'b0; #1 r = int'(uio_out);
      sel = 1'b1; #1 f = int'(uio_out);
      sel = 1'b0;
   endtask

   task automatic do_run(input bit hold);
      int n = 0;
      bit seen = 1'b0, finished = 1'b0;
      logic pb = 1'b0, ps;
      dq.delete();
      for (int i = 0; i < ITERS; i++) begin
         dq.push_back(rdly[i]);
         dq.push_back(fdly[i]);
      end
      dly = '0;
      slo = 0; rises = 0; falls = 0; runs = 0; lat1 = -1; lat2 = -1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); if (!hold) start = 1'b0;
      ps = uo_out[0];
      while (!finished && n < 20000) begin
         @(negedge clk);
         n++;
         if (n == 1) lat1 = int'(uo_out[7:5]);
         if (n == 2) lat2 = int'(uo_out[7:5]);
         if (uo_out[1] && !pb) runs++;
         if (uo_out[0] && !ps) rises++;
         if (!uo_out[0] && ps) falls++;
         if (uo_out[7:5] == 3'd1) slo++;
         pb = uo_out[1];
         ps = uo_out[0];
         if (uo_out[1]) seen = 1'b1;
         else if (seen) finished = 1'b1;
      end
      if (!finished) check("run_bound", 0, 1);
      st = int'(uo_out[7:5]);
   endtask

   task automatic expect_done(input string tag);
      int r, f;
      exp_rise = avg_of(rdly);
      exp_fall = avg_of(fdly);
      check({tag, "_state"}, st, 5);
      check({tag, "_flags"}, uo_out[4:1], 4'b0010);
      read_res(r, f);
      check({tag, "_rise"}, r, exp_rise);
      check({tag, "_fall"}, f, exp_fall);
   endtask

   task automatic expect_results(input string tag);
      int r, f;
      read_res(r, f);
      check({tag, "_rise"}, r, exp_rise);
      check({tag, "_fall"}, f, exp_fall);
   endtask

   initial begin
      int r, f, n, extra;
      int pat[4] = '{1, 1, 2, 2};
      logic pb;

      repeat (3) @(negedge clk);
      check("rst_uo", uo_out, 0);
      check("rst_uio", uio_out, 0);
      check("uio_oe", uio_oe, 8'hFF);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Zero-delay loop with start latency and stimulus sequence.
      for (int i = 0; i < ITERS; i++) begin rdly[i] = 0; fdly[i] = 0; end
      do_run(1'b0);
      check("lat_e1", lat1, 0);
      check("lat_e2", lat2, 1);
      check("zero_rises", rises, ITERS);
      check("zero_falls", falls, ITERS);
      check("zero_settle_lo", slo, ITERS * SETTLE);
      check("zero_stim", uo_out[0], 0);
      expect_done("zero");

      for (int i = 0; i < ITERS; i++) begin rdly[i] = 5; fdly[i] = 5; end
      do_run(1'b0);
      expect_done("d5");

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < ITERS; i++) begin
            rdly[i] = $urandom_range(0, 12);
            fdly[i] = $urandom_range(0, 12);
         end
         inv_exp  = 1'($urandom_range(0, 1));
         loop_inv = inv_exp;
         repeat (4) @(negedge clk);
         do_run(1'b0);
         expect_done("rand");
      end
      inv_exp = 1'b0; loop_inv = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < ITERS; i++) begin rdly[i] = pat[i]; fdly[i] = pat[i]; end
      do_run(1'b0);
      expect_done("avg_pat");
      read_res(r, f);
      check("avg_pat_const", r, 3);

      // Broken loop: rise never arrives.
      loop_broken = 1'b1;
      do_run(1'b0);
      if (ITERS == 1) exp_rise = CMAX;
      check("broken_state", st, 6);
      check("broken_flags", uo_out[4:1], 4'b0100);
      check("broken_stim", uo_out[0], 0);
      expect_results("broken");
      loop_broken = 1'b0;
      repeat (4) @(negedge clk);

      // Inverting loop, wrong then right expectation.
      loop_inv = 1'b1;
      repeat (4) @(negedge clk);
      do_run(1'b0);
      check("perr_settle_lo", slo, SETTLE);
      check("perr_state", st, 6);
      check("perr_flags", uo_out[4:1], 4'b1000);
      expect_results("perr");
      inv_exp = 1'b1;
      for (int i = 0; i < ITERS; i++) begin rdly[i] = 0; fdly[i] = 0; end
      do_run(1'b0);
      expect_done("inv_ok");
      inv_exp = 1'b0; loop_inv = 1'b0;

      // Match on the saturation cycle counts as a match.
      repeat (300) @(negedge clk);
      for (int i = 0; i < ITERS; i++) begin rdly[i] = 253; fdly[i] = 253; end
      do_run(1'b0);
      expect_done("sat_match");
      repeat (300) @(negedge clk);

      // Reset in the middle of RISE.
      dq.delete(); dq.push_back(30); dly = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (n < 200 && uo_out[7:5] != 3'd2) begin @(negedge clk); n++; end
      check("reach_rise", uo_out[7:5], 2);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      dq.delete();
      @(negedge clk);
      check("midrst_uo", uo_out, 0);
      exp_rise = 0; exp_fall = 0;
      expect_results("midrst");
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      for (int i = 0; i < ITERS; i++) begin rdly[i] = 1; fdly[i] = 1; end
      do_run(1'b0);
      expect_done("post_rst");

      // Start held high through DONE.
      for (int i = 0; i < ITERS; i++) begin rdly[i] = 0; fdly[i] = 0; end
      do_run(1'b1);
      expect_done("hold");
      check("hold_runs", runs, 1);
      extra = 0; pb = uo_out[1];
      repeat (40) begin
         @(negedge clk);
         if (uo_out[1] && !pb) extra++;
         pb = uo_out[1];
      end
      check("hold_extra_runs", extra, 0);
      check("hold_state", uo_out[7:5], 5);
      start = 1'b0;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
